// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding block: forward selects and write-back sources.
// No logic and no latency; backpressure does not apply.
// Holds the forward-priority helper used once per source operand.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] WB_DMEM  = 2'b00;
    localparam logic [1:0] WB_ALU   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;

    // m = {match_ex, match_mem}; the younger producer in MEM beats the one in WB
    function automatic logic [1:0] fwd_sel(input logic [1:0] m, input logic wb_en);
        if (m[1]) begin
            return FWD_MEM;
        end
        if (m[0] && wb_en) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Compares one ID source index against the EX and MEM shadow producers.
// Purely combinational; no backpressure.
// x0 and unused sources never match.
module fwd_match #(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] src,
    input  logic            used,
    input  logic            ex_valid,
    input  logic            ex_wen,
    input  logic [REGW-1:0] ex_rd,
    input  logic            mem_valid,
    input  logic            mem_wen,
    input  logic [REGW-1:0] mem_rd,
    output logic [1:0]      match
);

    logic live;

    assign live  = used & (src != '0);
    assign match = {live & ex_valid  & ex_wen  & (ex_rd  == src),
                    live & mem_valid & mem_wen & (mem_rd == src)};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: ID stall/bubble generation and registered EX operand-forward selects.
// stall/bubble are combinational from ID and shadow state; forwardA/B land one edge after ID.
// Backpressure is the stall output itself; redirect overrides it. Option: HAZARD_WB_FWD_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGW  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_rs1,
    input  logic [REGW-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_wen,
    input  logic [REGW-1:0]  id_rd,
    input  logic [1:0]       id_wbsel,
    input  logic             redirect,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef HAZARD_WB_FWD_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif

    logic            ex_valid, ex_wen, mem_valid, mem_wen;
    logic [REGW-1:0] ex_rd, mem_rd;
    logic [1:0]      ex_wbsel;
    logic [1:0]      m1, m2;
    logic            ex_hit, hazard;

    fwd_match #(.REGW(REGW)) u_match1 (
        .src(id_rs1), .used(id_use1),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .match(m1)
    );

    fwd_match #(.REGW(REGW)) u_match2 (
        .src(id_rs2), .used(id_use2),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
        .match(m2)
    );

    // Only ALU results are ready at the end of EX; loads and PC+4 links must wait a cycle
    always_comb begin
        ex_hit = (m1[1] | m2[1]) & (ex_wbsel != WB_ALU);
        hazard = ex_hit;
        if (!WB_EN) begin
            hazard = ex_hit | m1[0] | m2[0];
        end
    end

    assign stall  = id_valid & hazard & ~redirect;
    assign bubble = stall | redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            forwardA  <= FWD_NONE;
            forwardB  <= FWD_NONE;
            stall_cnt <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_wen   <= ex_wen;
            mem_rd    <= ex_rd;
            ex_valid  <= id_valid & ~bubble;
            ex_wen    <= id_wen;
            ex_rd     <= id_rd;
            ex_wbsel  <= id_wbsel;
            forwardA  <= bubble ? FWD_NONE : fwd_sel(m1, WB_EN);
            forwardB  <= bubble ? FWD_NONE : fwd_sel(m2, WB_EN);
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic against an
// instruction-history reference model; narrow stall counter so saturation is reached.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REGW   = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MX = (1 << CNT_W) - 1;

`ifdef HAZARD_WB_FWD_EN
    localparam bit WB_FWD = 1'b1;
`else
    localparam bit WB_FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_use1, id_use2, id_wen, redirect;
    logic [REGW-1:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]       id_wbsel;
    logic             stall, bubble;
    logic [1:0]       forwardA, forwardB;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REGW(REGW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_wen(id_wen), .id_rd(id_rd), .id_wbsel(id_wbsel), .redirect(redirect),
        .stall(stall), .bubble(bubble), .forwardA(forwardA), .forwardB(forwardB),
        .stall_cnt(stall_cnt)
    );

    // Reference: the instructions issued one and two cycles ago (now in EX and MEM)
    typedef struct {
        bit       v;
        bit       wen;
        bit [4:0] rd;
        bit [1:0] wbsel;
    } ins_t;

    ins_t        older [2];
    int          exp_cnt;
    bit [1:0]    exp_fa, exp_fb;
    bit          last_stall;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit writes(input bit [4:0] s, input bit u, input ins_t i);
        return u && (s != 0) && i.v && i.wen && (i.rd == s);
    endfunction

    function automatic bit ref_stall();
        bit h;
        h = (writes(id_rs1, id_use1, older[0]) || writes(id_rs2, id_use2, older[0]))
            && (older[0].wbsel != WB_ALU);
        if (!WB_FWD) begin
            h = h || writes(id_rs1, id_use1, older[1]) || writes(id_rs2, id_use2, older[1]);
        end
        return id_valid && h && !redirect;
    endfunction

    function automatic bit [1:0] ref_fwd(input bit [4:0] s, input bit u);
        if (writes(s, u, older[0])) return FWD_MEM;
        if (WB_FWD && writes(s, u, older[1])) return FWD_WB;
        return FWD_NONE;
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input bit wen, input int rd, input bit [1:0] wbsel);
        id_valid = v;    id_rs1  = rs1[REGW-1:0]; id_use1 = u1;
        id_rs2   = rs2[REGW-1:0]; id_use2 = u2;
        id_wen   = wen;  id_rd   = rd[REGW-1:0];  id_wbsel = wbsel;
    endtask

    // One clock: check combinational outputs, advance model over the edge, check registered ones
    task automatic step();
        bit       st, bb;
        bit [1:0] fa, fb;
        ins_t     issued;
        #1;
        st = ref_stall();
        bb = st || redirect;
        check("stall", stall, st);
        check("bubble", bubble, bb);
        fa = ref_fwd(id_rs1, id_use1);
        fb = ref_fwd(id_rs2, id_use2);
        issued = '{v: id_valid && !bb, wen: id_wen, rd: id_rd, wbsel: id_wbsel};
        @(posedge clk);
        if (rst) begin
            older[0] = '{v: 0, wen: 0, rd: 0, wbsel: 0};
            older[1] = older[0];
            exp_fa = FWD_NONE; exp_fb = FWD_NONE; exp_cnt = 0;
            last_stall = 1'b0;
        end else begin
            older[1] = older[0];
            older[0] = issued;
            exp_fa = bb ? FWD_NONE : fa;
            exp_fb = bb ? FWD_NONE : fb;
            if (st && exp_cnt < CNT_MX) exp_cnt++;
            last_stall = st;
        end
        #1;
        check("forwardA", forwardA, exp_fa);
        check("forwardB", forwardB, exp_fb);
        check("stall_cnt", stall_cnt, exp_cnt);
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, WB_ALU);
    endtask

    initial begin
        int n;
        int cnt0;
        rst = 1'b1; redirect = 1'b0;
        nop();
        older[0] = '{v: 0, wen: 0, rd: 0, wbsel: 0};
        older[1] = older[0];
        exp_cnt = 0; last_stall = 1'b0;
        repeat (2) step();
        check("rst_fwdA", forwardA, FWD_NONE);
        check("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        step();

        // ALU x5 -> immediate consumer on rs1
        set_id(1, 0, 0, 0, 0, 1, 5, WB_ALU); step();
        set_id(1, 5, 1, 0, 0, 0, 0, WB_ALU); step();
        check("alu_fwdA", forwardA, FWD_MEM);
        nop(); step(); step();

        // ALU x5, unrelated, then consumer on rs2
        set_id(1, 0, 0, 0, 0, 1, 5, WB_ALU); step();
        set_id(1, 1, 1, 2, 1, 1, 3, WB_ALU); step();
        set_id(1, 0, 0, 5, 1, 0, 0, WB_ALU);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_stall) n++; else break;
        end
        check("gap_stalls", n, WB_FWD ? 0 : 1);
        check("gap_fwdB", forwardB, WB_FWD ? FWD_WB : FWD_NONE);
        nop(); step(); step();

        // Load x7 -> immediate consumer
        cnt0 = stall_cnt;
        set_id(1, 0, 0, 0, 0, 1, 7, WB_DMEM); step();
        set_id(1, 7, 1, 0, 0, 1, 4, WB_ALU);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_stall) n++; else break;
        end
        check("ld_stalls", n, WB_FWD ? 1 : 2);
        check("ld_cnt", stall_cnt, cnt0 + (WB_FWD ? 1 : 2));
        check("ld_fwdA", forwardA, WB_FWD ? FWD_WB : FWD_NONE);
        nop(); step(); step();

        // Load x7 then consumer with redirect in the same cycle
        cnt0 = stall_cnt;
        set_id(1, 0, 0, 0, 0, 1, 7, WB_DMEM); step();
        set_id(1, 7, 1, 0, 0, 1, 4, WB_ALU); redirect = 1'b1; step();
        redirect = 1'b0;
        check("redir_cnt", stall_cnt, cnt0);
        check("redir_fwdA", forwardA, FWD_NONE);
        nop(); step(); step();

        // x0 producer/consumer
        set_id(1, 0, 0, 0, 0, 1, 0, WB_DMEM); step();
        set_id(1, 0, 1, 0, 1, 0, 0, WB_ALU); step();
        check("x0_fwdA", forwardA, FWD_NONE);
        check("x0_fwdB", forwardB, FWD_NONE);
        nop(); step();

        // Reset while a load-use stall is pending
        set_id(1, 0, 0, 0, 0, 1, 7, WB_DMEM); step();
        set_id(1, 7, 1, 0, 0, 1, 4, WB_ALU); rst = 1'b1; step();
        rst = 1'b0;
        check("rstmid_cnt", stall_cnt, 0);
        check("rstmid_fwdA", forwardA, FWD_NONE);
        #1;
        check("rstmid_stall", stall, 0);
        step();

        // Randomized traffic; ID is held while stalled, as IF/ID would be
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                set_id($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3), 2'($urandom_range(0, 2)));
            end
            redirect = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; redirect = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: REGW, 5, register-index width.
REQ-002 Parameter: CNT_W, 32, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_rs1, id_rs2  in  REGW  ID source indices.
REQ-007 id_use1, id_use2  in  1  ID instruction reads rs1 / rs2.
REQ-008 id_wen  in  1  ID instruction writes rd.
REQ-009 id_rd  in  REGW  ID destination index.
REQ-010 id_wbsel  in  2  ID write-back source: 00 dmem, 01 ALU, 10 PC+4.
REQ-011 redirect  in  1  EX-stage taken branch/jump; flush ID.
REQ-012 stall  out  1  combinational; hold PC and IF/ID.
REQ-013 bubble  out  1  combinational; load NOP into ID/EX.
REQ-014 forwardA, forwardB  out  2  registered ALU operand-select for the instruction in EX: 10 MEM ALU result, 01 WB data, 00 none.
REQ-015 stall_cnt  out  CNT_W  count of stall cycles.

Function
REQ-016 Shadow pipeline ex_* and mem_* holding {valid, wen, rd, wbsel}, updated every edge: mem_* <= ex_*; ex_* <= bubble ? invalid : ID fields.
REQ-017 A source s "matches" a stage when id_use for s=1, s!=0, stage valid, stage wen, and stage rd==s.
REQ-018 Hazard (macro defined): a source matches ex_* with ex_wbsel!=01.
REQ-019 stall = id_valid & hazard & ~redirect; bubble = stall | redirect.
REQ-020 redirect has priority over stall: ID is discarded, no stall asserted, stall_cnt not incremented.
REQ-021 Forward select, computed in ID and registered into forwardX on any edge where bubble=0: 10 if source matches ex_*, else 01 if it matches mem_*, else 00; MEM beats WB.
REQ-022 On an edge with bubble=1, forwardA and forwardB register 00.
REQ-023 Register x0 is never forwarded and never causes a stall.
REQ-024 Register file provides same-cycle write-through; WB-retiring producers need no forward from this block.
REQ-025 Load-use (macro defined): exactly 1 stall cycle, then forward 01.
REQ-026 stall_cnt increments by 1 per cycle with stall=1, saturates at all-ones.

Reset
REQ-027 While rst=1: ex_valid, mem_valid = 0; forwardA, forwardB = 00; stall_cnt = 0.
REQ-028 stall and bubble are 0 during and in the first cycle after reset unless driven by inputs; rst mid-stall clears shadow state, and the next cycle has no hazard.

Configuration
REQ-029 Macro HAZARD_WB_FWD_EN.
- Defined: REQ-018 and REQ-021 as written.
- Undefined: forwardX never 01; hazard additionally includes any source match on mem_*; load-use costs 2 stall cycles.

Structure
REQ-030 Package hazard_pkg holds FWD_NONE=00, FWD_WB=01, FWD_MEM=10 and WB_DMEM=00, WB_ALU=01, WB_PC=10.
REQ-031 One sub-module fwd_match, instantiated once per source, returns {match_ex, match_mem} for one source index.

Verification
REQ-032 ALU writes x5, next instr reads x5 as rs1 -> no stall, forwardA=10 in consumer's EX cycle.
REQ-033 ALU writes x5, one unrelated instr, then instr reads x5 as rs2 -> forwardB=01 (macro defined); 1 stall, then forwardB=00 (macro undefined).
REQ-034 Load writes x7, next instr reads x7 -> stall=1 for 1 cycle, stall_cnt +1, then forwardA=01 (defined); 2 stall cycles (undefined).
REQ-035 Load to x7 in EX, consumer of x7 in ID, redirect=1 same cycle -> stall=0, bubble=1, stall_cnt unchanged, next forwardA=00.
REQ-036 Producer writes x0, consumer reads x0 -> no stall, forward 00. rst asserted mid-stall -> all outputs 00/0 next cycle.
